// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift engine: op-code encoding and op classification.
package usr_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_SHL   = 3'd1,
    OP_SHR   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_ROTL  = 3'd4,
    OP_ROTR  = 3'd5,
    OP_ASR   = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  // Multi-step ops honour cmd_amount; the rest complete in one cycle.
  function automatic logic is_shift_op(input op_e op);
    logic res;
    case (op)
      OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR: res = 1'b1;
      default:                                  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/usr_step_unit.sv
// Combinational single-step datapath: produces the next register value and the bit
// ejected (or wrapped) by one shift/rotate step.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             serial_in_left_i,
  input  logic             serial_in_right_i,
  output logic [WIDTH-1:0] r_o,
  output logic             bit_o
);

  // One step of the selected op; non-shift codes pass the register through.
  always_comb begin
    r_o   = r_i;
    bit_o = 1'b0;
    case (op_e'(op_i))
      OP_SHL: begin
        r_o   = {r_i[WIDTH-2:0], serial_in_right_i};
        bit_o = r_i[WIDTH-1];
      end
      OP_SHR: begin
        r_o   = {serial_in_left_i, r_i[WIDTH-1:1]};
        bit_o = r_i[0];
      end
      OP_ROTL: begin
        r_o   = {r_i[WIDTH-2:0], r_i[WIDTH-1]};
        bit_o = r_i[WIDTH-1];
      end
      OP_ROTR: begin
        r_o   = {r_i[0], r_i[WIDTH-1:1]};
        bit_o = r_i[0];
      end
      OP_ASR: begin
        r_o   = {r_i[WIDTH-1], r_i[WIDTH-1:1]};
        bit_o = r_i[0];
      end
      default: begin
        r_o   = r_i;
        bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/usr_shift_engine.sv
// Command-driven universal shift register: single-cycle load/clear/nop and
// multi-step shifts/rotates advancing one bit per clock, with busy/done and abort.
module usr_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic             abort,
  output logic [WIDTH-1:0] parallel_out,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             shout_q, shout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;

  op_e              cmd_op_s;
  op_e              step_op_s;
  logic             accept_s;
  logic [WIDTH-1:0] step_r_s;
  logic             step_bit_s;

  assign cmd_op_s  = op_e'(cmd_op);
  assign accept_s  = cmd_valid & ~busy_q;
  // While busy the latched op drives the step unit; when idle the incoming op does.
  assign step_op_s = busy_q ? op_q : cmd_op_s;

  usr_step_unit #(.WIDTH(WIDTH)) u_step (
    .r_i               (reg_q),
    .op_i              (step_op_s),
    .serial_in_left_i  (serial_in_left),
    .serial_in_right_i (serial_in_right),
    .r_o               (step_r_s),
    .bit_o             (step_bit_s)
  );

  // Next-state: command accept, step sequencing and abort.
  always_comb begin
    reg_d   = reg_q;
    shout_d = shout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (accept_s) begin
      if (is_shift_op(cmd_op_s)) begin
        if (cmd_amount == AMT_ZERO) begin
          done_d = 1'b1;
        end else begin
          reg_d   = step_r_s;
          shout_d = step_bit_s;
          cnt_d   = cmd_amount - AMT_ONE;
          busy_d  = (cmd_amount != AMT_ONE);
          done_d  = (cmd_amount == AMT_ONE);
          op_d    = cmd_op_s;
        end
      end else begin
        done_d = 1'b1;
        case (cmd_op_s)
          OP_LOAD:  reg_d = parallel_in;
          OP_CLEAR: reg_d = {WIDTH{1'b0}};
          default:  reg_d = reg_q;
        endcase
      end
    end else if (busy_q) begin
      if (abort) begin
        busy_d = 1'b0;
        cnt_d  = AMT_ZERO;
        done_d = 1'b1;
      end else begin
        reg_d   = step_r_s;
        shout_d = step_bit_s;
        cnt_d   = cnt_q - AMT_ONE;
        busy_d  = (cnt_q != AMT_ONE);
        done_d  = (cnt_q == AMT_ONE);
      end
    end else begin
      reg_d = reg_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q   <= {WIDTH{1'b0}};
      shout_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= AMT_ZERO;
      op_q    <= OP_NOP;
    end else begin
      reg_q   <= reg_d;
      shout_q <= shout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign parallel_out = reg_q;
  assign shift_out    = shout_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cmd_ready    = ~busy_q;

endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed self-checking bench for usr_shift_engine (WIDTH=8, AMT_W=4).
module tb_usr_shift_engine;
  import usr_pkg::*;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amount;
  logic [7:0] parallel_in;
  logic       serial_in_left;
  logic       serial_in_right;
  logic       abort;
  logic [7:0] parallel_out;
  logic       shift_out;
  logic       busy;
  logic       done;

  int total_cnt  = 0;
  int passed_cnt = 0;

  usr_shift_engine #(.WIDTH(8), .AMT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_amount      (cmd_amount),
    .parallel_in     (parallel_in),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .abort           (abort),
    .parallel_out    (parallel_out),
    .shift_out       (shift_out),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      passed_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (engine assumed idle).
  task automatic issue(input op_e op, input logic [3:0] amt, input logic [7:0] pin);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_amount  = amt;
    parallel_in = pin;
    tick();
    cmd_valid   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_amount = 4'd0;
    parallel_in = 8'h00; serial_in_left = 1'b0; serial_in_right = 1'b0; abort = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_po", parallel_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);

    // LOAD 0xA5: one-cycle done, never busy
    issue(OP_LOAD, 4'd0, 8'hA5);
    chk("load_po", parallel_out, 8'hA5);
    chk("load_done", done, 1'b1);
    chk("load_busy", busy, 1'b0);
    tick();
    chk("load_done_off", done, 1'b0);

    // LOAD 0x81 then ROTL 3
    issue(OP_LOAD, 4'd0, 8'h81);
    issue(OP_ROTL, 4'd3, 8'h00);
    chk("rotl_s1_po", parallel_out, 8'h03);
    chk("rotl_s1_so", shift_out, 1'b1);
    chk("rotl_s1_busy", busy, 1'b1);
    chk("rotl_s1_ready", cmd_ready, 1'b0);
    tick();
    chk("rotl_s2_po", parallel_out, 8'h06);
    chk("rotl_s2_so", shift_out, 1'b0);
    chk("rotl_s2_busy", busy, 1'b1);
    chk("rotl_s2_done", done, 1'b0);
    tick();
    chk("rotl_s3_po", parallel_out, 8'h0C);
    chk("rotl_s3_busy", busy, 1'b0);
    chk("rotl_s3_done", done, 1'b1);
    tick();
    chk("rotl_done_off", done, 1'b0);

    // LOAD 0x80 then ASR 4 -> 0xF8
    issue(OP_LOAD, 4'd0, 8'h80);
    issue(OP_ASR, 4'd4, 8'h00);
    chk("asr_s1_po", parallel_out, 8'hC0);
    tick(); tick(); tick();
    chk("asr_po", parallel_out, 8'hF8);
    chk("asr_so", shift_out, 1'b0);
    chk("asr_done", done, 1'b1);

    // SHL 10 with serial_in_right=1 from 0x00 -> 0xFF
    issue(OP_LOAD, 4'd0, 8'h00);
    serial_in_right = 1'b1;
    issue(OP_SHL, 4'd10, 8'h00);
    chk("shl_s1_po", parallel_out, 8'h01);
    chk("shl_s1_busy", busy, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    chk("shl_po", parallel_out, 8'hFF);
    chk("shl_so", shift_out, 1'b1);
    chk("shl_busy", busy, 1'b0);
    chk("shl_done", done, 1'b1);
    serial_in_right = 1'b0;

    // SHR with N=0: no change, done pulses
    issue(OP_SHR, 4'd0, 8'h00);
    chk("shr0_po", parallel_out, 8'hFF);
    chk("shr0_done", done, 1'b1);
    chk("shr0_busy", busy, 1'b0);
    tick();
    chk("shr0_done_off", done, 1'b0);

    // LOAD 0xFF, SHR 8, abort after second step
    issue(OP_LOAD, 4'd0, 8'hFF);
    serial_in_left = 1'b0;
    issue(OP_SHR, 4'd8, 8'h00);
    chk("shr_s1_po", parallel_out, 8'h7F);
    tick();
    chk("shr_s2_po", parallel_out, 8'h3F);
    chk("shr_s2_so", shift_out, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_po", parallel_out, 8'h3F);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b1);
    tick();
    chk("abort_po_hold", parallel_out, 8'h3F);
    chk("abort_done_off", done, 1'b0);

    // ROTR 3 from 0x3F while a LOAD 0x11 is held pending
    issue(OP_ROTR, 4'd3, 8'h00);
    chk("rotr_s1_po", parallel_out, 8'h9F);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_amount = 4'd0; parallel_in = 8'h11;
    tick();
    chk("hold_s2_po", parallel_out, 8'hCF);
    chk("hold_ready", cmd_ready, 1'b0);
    tick();
    chk("hold_s3_po", parallel_out, 8'hE7);
    chk("hold_s3_done", done, 1'b1);
    chk("hold_s3_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_load_po", parallel_out, 8'h11);
    chk("hold_load_done", done, 1'b1);
    tick();
    chk("hold_after_po", parallel_out, 8'h11);
    chk("hold_after_done", done, 1'b0);
    chk("hold_after_busy", busy, 1'b0);

    // Abort coinciding with accept does not cancel the new command
    abort = 1'b1;
    issue(OP_ROTL, 4'd2, 8'h00);
    abort = 1'b0;
    chk("abacc_po", parallel_out, 8'h22);
    chk("abacc_busy", busy, 1'b1);
    tick();
    chk("abacc_s2_po", parallel_out, 8'h44);
    chk("abacc_done", done, 1'b1);

    // Reset mid ROTL 10
    issue(OP_ROTL, 4'd10, 8'h00);
    chk("rrot_s1_po", parallel_out, 8'h88);
    tick();
    chk("rrot_s2_po", parallel_out, 8'h11);
    chk("rrot_s2_so", shift_out, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_po", parallel_out, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_ready", cmd_ready, 1'b1);
    chk("mrst_so", shift_out, 1'b0);
    tick(); tick();
    chk("mrst_idle_po", parallel_out, 8'h00);
    chk("mrst_idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
